// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings, FSM states and byte-enable constants.
// Used by load_store_unit and lsu_align.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_e;

  // funct3[1:0]: 00 byte, 01 half, anything else is a word
  function automatic lsu_size_e f3_size(
    input logic [1:0] f3
  );
    unique case (f3)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane enables, store lane replication and load extraction/extension.
// Misaligned low offset bits are dropped to the access size boundary.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  lsu_size_e   size;
  logic [1:0]  lane;
  logic [31:0] shifted;

  assign size = f3_size(funct3_i[1:0]);

  always_comb begin
    lane    = 2'b00;
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    unique case (1'b1)
      (size == SZ_B): begin
        lane    = off_i;
        be_o    = BE_BYTE << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      (size == SZ_H): begin
        lane    = {off_i[1], 1'b0};
        be_o    = BE_HALF << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        lane = 2'b00;
      end
    endcase
  end

  assign shifted = rdata_i >> {lane, 3'b000};

  always_comb begin
    unique case (funct3_i)
      F3_LB:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  rdata_o = {24'h0, shifted[7:0]};
      F3_LHU:  rdata_o = {16'h0, shifted[15:0]};
      F3_LW:   rdata_o = shifted;
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE/ACCESS/RESP FSM with registered outputs.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  lsu_state_e  state_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        st_q;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic        wb_valid_q;
  logic        wb_we_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic        idle;
  logic        is_mem;
  logic [1:0]  al_off;
  logic [2:0]  al_f3;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign idle   = (state_q == S_IDLE);
  assign is_mem = ex_load | ex_store;

  // Aligner sees the incoming op in IDLE, the latched op afterwards
  assign al_off = idle ? ex_addr[1:0] : off_q;
  assign al_f3  = idle ? ex_funct3 : f3_q;

  lsu_align u_align (
    .off_i    (al_off),
    .funct3_i (al_f3),
    .wdata_i  (ex_wdata),
    .rdata_i  (mem_rdata),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  lsu_size_e ex_size;
  logic      mis_w;
  logic      misalign_q;

  assign ex_size = f3_size(ex_funct3[1:0]);
  assign mis_w   = ((ex_size == SZ_H) & ex_addr[0]) |
                   ((ex_size == SZ_W) & (|ex_addr[1:0]));
  assign misalign = misalign_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      rd_q        <= 5'd0;
      st_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (ex_valid && !is_mem) begin
            wb_valid_q <= 1'b1;
            wb_we_q    <= (ex_rd != 5'd0);
            wb_rd_q    <= ex_rd;
            wb_data_q  <= ex_addr;
`ifdef LSU_MISALIGN_TRAP_EN
          end else if (ex_valid && mis_w) begin
            wb_valid_q <= 1'b1;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= ex_rd;
            wb_data_q  <= ex_addr;
            misalign_q <= 1'b1;
`endif
          end else if (ex_valid) begin
            state_q     <= S_ACCESS;
            off_q       <= ex_addr[1:0];
            f3_q        <= ex_funct3;
            rd_q        <= ex_rd;
            st_q        <= ex_store;
            mem_req_q   <= 1'b1;
            mem_we_q    <= ex_store;
            mem_addr_q  <= {ex_addr[31:2], 2'b00};
            mem_be_q    <= al_be;
            mem_wdata_q <= al_wdata;
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            state_q    <= S_RESP;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_we_q    <= !st_q && (rd_q != 5'd0);
            wb_rd_q    <= rd_q;
            wb_data_q  <= st_q ? 32'h0 : al_rdata;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ex_ready  = idle;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 ex_valid  in  1  execute stage presents an instruction.
REQ-005 ex_ready  out  1  unit accepts the instruction this cycle.
REQ-006 ex_addr  in  32  ALU result: the effective address for load/store, or the result value otherwise.
REQ-007 ex_wdata  in  32  store data (rs2).
REQ-008 ex_load / ex_store  in  1 each  instruction is a load / store; both low means a non-memory operation.
REQ-009 ex_funct3  in  3  RV32I width/sign code.
REQ-010 ex_rd  in  5  destination register.
REQ-011 mem_req  out  1  memory access request.
REQ-012 mem_we  out  1  1 for a write.
REQ-013 mem_addr  out  32  word-aligned address, bits [1:0] = 0.
REQ-014 mem_be  out  4  byte enables.
REQ-015 mem_wdata  out  32  lane-replicated write data.
REQ-016 mem_ack  in  1  memory completes the access; mem_rdata is valid in the same cycle.
REQ-017 mem_rdata  in  32  read word.
REQ-018 wb_valid  out  1  one-cycle pulse: result is ready for writeback.
REQ-019 wb_we  out  1  register-file write enable qualifying wb_valid.
REQ-020 wb_rd  out  5  destination register.
REQ-021 wb_data  out  32  writeback value.

Function
REQ-022 The FSM SHALL have three states: IDLE, ACCESS and RESP. ex_ready SHALL be 1 only in IDLE.
REQ-023 In IDLE, ex_valid=1 with ex_load=ex_store=0 SHALL cause, on the next cycle: wb_valid=1, wb_we=(ex_rd!=0), wb_data=ex_addr. The state SHALL stay IDLE, giving 1-cycle latency and full throughput.
REQ-024 In IDLE, ex_valid=1 with a load or store SHALL register the address, data, funct3 and rd, and move to ACCESS.
REQ-025 In ACCESS, mem_req SHALL be 1 and mem_we, mem_addr, mem_be and mem_wdata SHALL be held stable until mem_ack=1.
REQ-026 mem_ack in ACCESS SHALL capture mem_rdata and move the FSM to RESP.
REQ-027 RESP SHALL pulse wb_valid for one cycle and return to IDLE. A memory operation therefore accepts the next instruction no earlier than 3 cycles after acceptance.
REQ-028 For loads in RESP, wb_we SHALL be (rd!=0). Stores SHALL give wb_we=0.
REQ-029 Byte enables SHALL be:
- byte (funct3 x00): 4'b0001<<addr[1:0].
- half (x01): 4'b0011<<{addr[1],1'b0}.
- word (010): 4'b1111.
- funct3 011/110/111 SHALL be treated as word.
REQ-030 mem_wdata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-031 Load data SHALL be rdata>>(8*addr[1:0]), then:
- sign-extended for LB (000) and LH (001);
- zero-extended for LBU (100) and LHU (101);
- unmodified for LW.
REQ-032 mem_ack while not in ACCESS SHALL be ignored.
REQ-033 ex_valid while not in IDLE SHALL be ignored (ex_ready=0).

Reset
REQ-034 rst SHALL force the following on the next edge, regardless of state (including mid-ACCESS): IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0.
REQ-035 A mem_ack arriving after a reset that abandoned an access SHALL be ignored.

Configuration
REQ-036 With macro LSU_MISALIGN_TRAP_EN defined:
- an extra output misalign (1 bit, reset 0) SHALL exist;
- a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL issue no mem_req;
- the next cycle SHALL give wb_valid=1, wb_we=0, misalign=1, and the FSM SHALL stay in IDLE.
REQ-037 Without LSU_MISALIGN_TRAP_EN, the misalign port SHALL be absent and misaligned accesses SHALL proceed with the offending low address bits treated as 0.

Structure
REQ-038 Funct3 width encodings, the FSM state enum and the byte-enable constants SHALL live in the shared riscv_pkg package.
REQ-039 Byte-lane generation and load extraction/extension SHALL be one combinational sub-module, lsu_align.

Verification
REQ-040 Non-memory op: ex_addr=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_we=1, wb_data=0x0000_1234.
REQ-041 LB at addr 0x103, rdata=0x80FF_FFFF, ack after 2 wait cycles -> mem_addr=0x100, mem_be=4'b1000, wb_data=0xFFFF_FF80.
REQ-042 SH at addr 0x202, wdata=0x0000_ABCD -> mem_we=1, mem_be=4'b1100, mem_wdata=0xABCD_ABCD, wb_we=0.
REQ-043 LHU at 0x2, rdata=0x8001_0000 -> wb_data=0x0000_8001. With rd=0 -> wb_we=0.
REQ-044 rst asserted in ACCESS, then mem_ack one cycle later -> IDLE, no wb_valid, mem_req=0.
REQ-045 LW at 0x101:
- with LSU_MISALIGN_TRAP_EN -> no mem_req, misalign=1 next cycle;
- without -> mem_addr=0x100, mem_be=4'b1111.
